reg_bank_8x32_scan: RTL and testbench
=====================================

// Module: reg_bank_8x32_scan
// PURPOSE
//   Upstream stage of the 8:1 32-bit select mux. Holds eight WIDTH-bit words
//   that drive the mux data inputs a..h (q0..q7), and generates the 3-bit mux
//   select. A built-in scan sequencer walks select 0..7 under a valid/ready
//   handshake so a downstream consumer can read every word in order.
// PARAMETERS
//   WIDTH      32   data width of each register and of the mux inputs
//   RESET_VAL  0    value loaded into every register on reset and on clr
// PORTS
//   clk         in   1      rising-edge clock
//   rst_n       in   1      asynchronous active-low reset
//   clr         in   1      synchronous clear of all eight registers
//   wr_en       in   1      write strobe
//   wr_addr     in   3      register index to write
//   wr_data     in   WIDTH  write data
//   scan_start  in   1      start a scan (sampled only in IDLE)
//   scan_abort  in   1      terminate a scan in progress
//   scan_ready  in   1      consumer accepts the current scan_sel
//   q0..q7      out  WIDTH  register contents, wired to mux inputs a..h
//   scan_sel    out  3      mux select
//   scan_valid  out  1      scan_sel is valid for the consumer
//   scan_done   out  1      one-cycle pulse after index 7 accepted
//   busy        out  1      high in SCAN state
// BEHAVIOUR
//   Reset (rst_n=0, async): q0..q7=RESET_VAL, state=IDLE, scan_sel=0,
//     scan_valid=0, scan_done=0, busy=0. Deassertion synchronous to clk.
//   Register writes:
//     - clr=1: all registers <= RESET_VAL next edge; clr beats wr_en.
//     - else wr_en=1: q[wr_addr] <= wr_data next edge (1-cycle latency).
//     - writes permitted in any state, incl. to the word being scanned;
//       new value visible on q* the cycle after the edge.
//   Scan FSM (states IDLE, SCAN, DONE):
//     IDLE: scan_valid=0, busy=0, scan_sel holds 0. scan_start=1 -> SCAN,
//       scan_sel=0, scan_valid=1 next cycle.
//     SCAN: busy=1, scan_valid=1. Handshake: transfer when
//       scan_valid&scan_ready at edge. scan_sel, scan_valid stable until
//       transfer. On transfer with scan_sel<7: scan_sel+1.
//       On transfer with scan_sel==7: -> DONE, scan_valid=0.
//     DONE: scan_done=1 for exactly one cycle, busy=0, scan_sel=0 -> IDLE.
//     scan_abort=1 in SCAN: -> IDLE next edge, scan_sel=0, scan_valid=0,
//       no scan_done; abort beats a concurrent transfer.
//     scan_start while SCAN or DONE: ignored (not queued).
//     scan_sel never wraps 7->0 within a scan; 8 transfers per full scan.
//   Max throughput: one word per cycle with scan_ready held high;
//     full scan = 1 start cycle + 8 transfer cycles + 1 DONE cycle.
// TESTING
//   1 Reset: rst_n=0 mid-scan (sel=4) -> immediately q*=0, sel=0, valid=0,
//     busy=0, no scan_done.
//   2 Write q0..q7 = 1..8, then scan with ready=1 -> sel 0..7 on consecutive
//     cycles, mux result 1..8, scan_done pulses once one cycle after sel=7.
//   3 Backpressure: ready low for 3 cycles at sel=2 -> sel stays 2, valid
//     stays 1; resumes 3..7 after ready returns.
//   4 Simultaneous clr and wr_en(addr=5,data=32'hDEAD_BEEF) -> q5=0, all q*=0.
//   5 Abort at sel=5 -> IDLE next cycle, sel=0, no scan_done; scan_start
//     during SCAN ignored (sel sequence unchanged).
//   6 Write q3=32'h55 while sel=3 and ready=0 -> q3 and mux result become
//     32'h55 the next cycle; sel unchanged.

Source files
------------

// File: rtl/reg_bank_8x32_scan.sv
// Eight-word register bank feeding the 8:1 select mux, plus a scan sequencer
// that walks the mux select 0..7 under a valid/ready handshake.
module reg_bank_8x32_scan #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [2:0]       wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             scan_start,
  input  logic             scan_abort,
  input  logic             scan_ready,
  output logic [WIDTH-1:0] q0,
  output logic [WIDTH-1:0] q1,
  output logic [WIDTH-1:0] q2,
  output logic [WIDTH-1:0] q3,
  output logic [WIDTH-1:0] q4,
  output logic [WIDTH-1:0] q5,
  output logic [WIDTH-1:0] q6,
  output logic [WIDTH-1:0] q7,
  output logic [2:0]       scan_sel,
  output logic             scan_valid,
  output logic             scan_done,
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  logic [WIDTH-1:0] regs_q [8];
  logic [WIDTH-1:0] regs_d [8];

  state_t     state_q;
  logic [2:0] sel_q;
  logic       valid_q;
  logic       done_q;
  logic       busy_q;

  // Clear takes priority over a write landing in the same cycle.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      regs_d[i] = regs_q[i];
      if (clr) begin
        regs_d[i] = RESET_VAL;
      end else if (wr_en && (wr_addr == 3'(i))) begin
        regs_d[i] = wr_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        regs_q[i] <= RESET_VAL;
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // While in SCAN valid is always high, so a transfer is simply scan_ready.
  // Abort is tested first so it wins over a concurrent transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= 3'd0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          sel_q   <= 3'd0;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          if (scan_start) begin
            state_q <= ST_SCAN;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        ST_SCAN: begin
          if (scan_abort) begin
            state_q <= ST_IDLE;
            sel_q   <= 3'd0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end else if (scan_ready) begin
            if (sel_q == 3'd7) begin
              state_q <= ST_DONE;
              sel_q   <= 3'd0;
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              sel_q <= sel_q + 3'd1;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          sel_q   <= 3'd0;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          sel_q   <= 3'd0;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign q0 = regs_q[0];
  assign q1 = regs_q[1];
  assign q2 = regs_q[2];
  assign q3 = regs_q[3];
  assign q4 = regs_q[4];
  assign q5 = regs_q[5];
  assign q6 = regs_q[6];
  assign q7 = regs_q[7];

  assign scan_sel   = sel_q;
  assign scan_valid = valid_q;
  assign scan_done  = done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_reg_bank_8x32_scan.sv
// Directed bench for reg_bank_8x32_scan: write table plus hand-written scan,
// backpressure, abort, mid-scan write, clear and reset sequences.
module tb_reg_bank_8x32_scan;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr, wr_en;
  logic [2:0]  wr_addr;
  logic [31:0] wr_data;
  logic        scan_start, scan_abort, scan_ready;
  logic [31:0] q0, q1, q2, q3, q4, q5, q6, q7;
  logic [2:0]  scan_sel;
  logic        scan_valid, scan_done, busy;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  reg_bank_8x32_scan #(.WIDTH(32), .RESET_VAL(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .scan_start(scan_start), .scan_abort(scan_abort),
    .scan_ready(scan_ready), .q0(q0), .q1(q1), .q2(q2), .q3(q3), .q4(q4),
    .q5(q5), .q6(q6), .q7(q7), .scan_sel(scan_sel), .scan_valid(scan_valid),
    .scan_done(scan_done), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (scan_done) done_cnt++;

  typedef struct {
    logic        clr;
    logic        wr_en;
    logic [2:0]  addr;
    logic [31:0] data;
    logic [2:0]  chk_idx;
    logic [31:0] exp_val;
  } vec_t;

  vec_t vecs [10];

  function automatic logic [31:0] qv(input logic [2:0] i);
    case (i)
      3'd0: qv = q0;
      3'd1: qv = q1;
      3'd2: qv = q2;
      3'd3: qv = q3;
      3'd4: qv = q4;
      3'd5: qv = q5;
      3'd6: qv = q6;
      default: qv = q7;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_scan(input string tag, input logic [2:0] sel, input logic v, input logic b);
    chk({tag, " sel"}, 32'(scan_sel), 32'(sel));
    chk({tag, " valid"}, 32'(scan_valid), 32'(v));
    chk({tag, " busy"}, 32'(busy), 32'(b));
  endtask

  task automatic chk_done_cycle(input string tag);
    chk({tag, " done pulse"}, 32'(scan_done), 32'd1);
    chk_scan({tag, " in DONE"}, 3'd0, 1'b0, 1'b0);
    step();
    chk({tag, " done low"}, 32'(scan_done), 32'd0);
    chk_scan({tag, " idle"}, 3'd0, 1'b0, 1'b0);
  endtask

  task automatic write_all_seq();
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_addr = 3'(i); wr_data = 32'(i + 1);
      step();
    end
    wr_en = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; clr = 1'b0; wr_en = 1'b0; wr_addr = 3'd0; wr_data = 32'h0;
    scan_start = 1'b0; scan_abort = 1'b0; scan_ready = 1'b0;

    for (int i = 0; i < 8; i++)
      vecs[i] = '{1'b0, 1'b1, 3'(i), 32'(i + 1), 3'(i), 32'(i + 1)};
    vecs[8] = '{1'b0, 1'b0, 3'd2, 32'hFFFF_0000, 3'd2, 32'd3};
    vecs[9] = '{1'b0, 1'b1, 3'd6, 32'd7, 3'd6, 32'd7};

    #12;
    chk_scan("reset", 3'd0, 1'b0, 1'b0);
    chk("reset done", 32'(scan_done), 32'd0);
    chk("reset q4", q4, 32'd0);
    rst_n = 1'b1;
    step();

    // Register writes from the table
    foreach (vecs[k]) begin
      clr = vecs[k].clr; wr_en = vecs[k].wr_en;
      wr_addr = vecs[k].addr; wr_data = vecs[k].data;
      step();
      chk($sformatf("vec%0d q%0d", k, vecs[k].chk_idx), qv(vecs[k].chk_idx), vecs[k].exp_val);
    end
    wr_en = 1'b0;

    // Full-rate scan
    done_cnt = 0;
    scan_ready = 1'b1; scan_start = 1'b1;
    step();
    scan_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk_scan($sformatf("scan i%0d", i), 3'(i), 1'b1, 1'b1);
      chk($sformatf("scan mux%0d", i), qv(scan_sel), 32'(i + 1));
      chk($sformatf("scan nodone%0d", i), 32'(scan_done), 32'd0);
      step();
    end
    chk_done_cycle("scan");
    step();
    chk("scan done count", 32'(done_cnt), 32'd1);

    // Backpressure at sel=2
    done_cnt = 0;
    scan_start = 1'b1;
    step();
    scan_start = 1'b0;
    step(); step();
    chk_scan("bp at2", 3'd2, 1'b1, 1'b1);
    scan_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_scan($sformatf("bp hold%0d", i), 3'd2, 1'b1, 1'b1);
    end
    scan_ready = 1'b1;
    step();
    for (int i = 3; i < 8; i++) begin
      chk_scan($sformatf("bp resume%0d", i), 3'(i), 1'b1, 1'b1);
      chk($sformatf("bp mux%0d", i), qv(scan_sel), 32'(i + 1));
      step();
    end
    chk_done_cycle("bp");
    chk("bp done count", 32'(done_cnt), 32'd1);

    // Start ignored mid-scan, then abort at sel=5 concurrent with ready
    done_cnt = 0;
    scan_start = 1'b1;
    step();
    scan_start = 1'b0;
    step();
    scan_start = 1'b1;
    step();
    scan_start = 1'b0;
    chk_scan("ab start ignored", 3'd2, 1'b1, 1'b1);
    step(); step(); step();
    chk_scan("ab at5", 3'd5, 1'b1, 1'b1);
    scan_abort = 1'b1;
    step();
    scan_abort = 1'b0;
    chk_scan("ab idle", 3'd0, 1'b0, 1'b0);
    step(); step();
    chk_scan("ab stay idle", 3'd0, 1'b0, 1'b0);
    chk("ab no done", 32'(done_cnt), 32'd0);

    // Write the word currently selected, under backpressure
    scan_start = 1'b1;
    step();
    scan_start = 1'b0;
    step(); step(); step();
    chk_scan("ws at3", 3'd3, 1'b1, 1'b1);
    scan_ready = 1'b0;
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 32'h55;
    step();
    wr_en = 1'b0;
    chk("ws q3", q3, 32'h55);
    chk("ws mux", qv(scan_sel), 32'h55);
    chk_scan("ws sel held", 3'd3, 1'b1, 1'b1);
    scan_ready = 1'b1;
    for (int i = 3; i < 8; i++) step();
    chk_done_cycle("ws");

    // Clear beats write
    clr = 1'b1; wr_en = 1'b1; wr_addr = 3'd5; wr_data = 32'hDEAD_BEEF;
    step();
    clr = 1'b0; wr_en = 1'b0;
    for (int i = 0; i < 8; i++) chk($sformatf("clr q%0d", i), qv(3'(i)), 32'd0);

    // Asynchronous reset mid-scan at sel=4
    write_all_seq();
    chk("pre-rst q7", q7, 32'd8);
    done_cnt = 0;
    scan_start = 1'b1;
    step();
    scan_start = 1'b0;
    step(); step(); step(); step();
    chk_scan("rst at4", 3'd4, 1'b1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_scan("rst async", 3'd0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) chk($sformatf("rst q%0d", i), qv(3'(i)), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk_scan("rst after", 3'd0, 1'b0, 1'b0);
    chk("rst no done", 32'(done_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
